// File: rtl/dma_sequencer.sv
// dma_sequencer: bus-master that copies a block of words between memory, I/O1 and I/O2.
// Latency: REQ one cycle after start, then 2 cycles per word while granted; done at start+2+2N.
// Backpressure: waits in REQ while grant is low; a word already read is always written next cycle.
module dma_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              grant,
    input  logic [DATA_W-1:0] rd_data,
    output logic              bus_req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_strobe,
    output logic [DATA_W-1:0] wr_data,
    output logic              memwrite,
    output logic              IOWrite1,
    output logic              IOWrite2
);

    // Memory occupies 0..MEM_LAST; I/O1 sits between it and IO2_BASE; I/O2 above.
    localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(191);
    localparam logic [ADDR_W-1:0] IO2_BASE = ADDR_W'(224);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  rem_q;
    logic [DATA_W-1:0] word_q;
    logic [ADDR_W-1:0] addr_q;

    // Memory addresses walk forward and wrap inside the memory region;
    // I/O addresses are FIFO-style ports and stay put.
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a);
        if (a == MEM_LAST) begin
            return '0;
        end else if (a < MEM_LAST) begin
            return a + ADDR_W'(1);
        end
        return a;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and bus strobes; addr falls back to the last value driven.
    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        bus_req   = 1'b0;
        done      = 1'b0;
        rd_strobe = 1'b0;
        memwrite  = 1'b0;
        IOWrite1  = 1'b0;
        IOWrite2  = 1'b0;
        addr      = addr_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (grant) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                bus_req   = 1'b1;
                rd_strobe = 1'b1;
                addr      = src_q;
                state_nx  = S_WRITE;
            end
            S_WRITE: begin
                bus_req = 1'b1;
                addr    = dst_q;
                if (dst_q <= MEM_LAST) begin
                    memwrite = 1'b1;
                end else if (dst_q < IO2_BASE) begin
                    IOWrite1 = 1'b1;
                end else begin
                    IOWrite2 = 1'b1;
                end
                if (rem_q == CNT_W'(1)) begin
                    state_nx = S_DONE;
                end else if (grant) begin
                    state_nx = S_READ;
                end else begin
                    state_nx = S_REQ;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Transfer registers: capture the request, hold the in-flight word, step addresses per word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            word_q <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (count != '0)) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= count;
                    end
                end
                S_READ: begin
                    word_q <= rd_data;
                    addr_q <= addr;
                end
                S_WRITE: begin
                    rem_q  <= rem_q - CNT_W'(1);
                    src_q  <= advance(src_q);
                    dst_q  <= advance(dst_q);
                    addr_q <= addr;
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_data = word_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: directed and randomized block moves against a word-level transfer model.
// The bus model serves reads (memory array, I/O ports as counting sources) and logs every strobe.
// Each transfer's writes, reads, done timing and bus_req usage are compared to the model.
module tb_dma_sequencer;

    logic        clock;
    logic        rst_n;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [5:0]  count;
    logic        grant;
    logic [31:0] rd_data;
    logic        bus_req;
    logic        busy;
    logic        done;
    logic [7:0]  addr;
    logic        rd_strobe;
    logic [31:0] wr_data;
    logic        memwrite;
    logic        IOWrite1;
    logic        IOWrite2;

    dma_sequencer #(.ADDR_W(8), .DATA_W(32), .CNT_W(6)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .grant    (grant),
        .rd_data  (rd_data),
        .bus_req  (bus_req),
        .busy     (busy),
        .done     (done),
        .addr     (addr),
        .rd_strobe(rd_strobe),
        .wr_data  (wr_data),
        .memwrite (memwrite),
        .IOWrite1 (IOWrite1),
        .IOWrite2 (IOWrite2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bus model (owned by the monitor / edge processes) ----------------
    logic [31:0]  mem [256];
    int unsigned  io_cnt = 0;
    int           cyc = 0;
    logic [41:0]  wlog[$];
    logic [7:0]   rlog[$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           breq_cyc = 0;
    int           req_cyc = 0;
    int           strobe_err = 0;

    // ---------------- reference model (owned by the stimulus process) ----------------
    logic [31:0]  ref_mem [256];
    int unsigned  ref_io = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [31:0] init_val(input int a);
        return 32'hD000_0000 ^ (32'(a) * 32'h0001_0203) ^ 32'(a);
    endfunction

    function automatic logic [1:0] region(input logic [7:0] a);
        if (a < 8'd192) return 2'd1;
        if (a < 8'd224) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] a);
        if (a < 8'd192) return 8'((int'(a) + 1) % 192);
        return a;
    endfunction

    // I/O ports act as sources returning a running sequence number.
    assign rd_data = (addr >= 8'd192) ? (32'hF000_0000 | io_cnt) : mem[addr];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rst_n && rd_strobe && (addr >= 8'd192)) io_cnt <= io_cnt + 1;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(negedge clock);
            if (rst_n) begin
                if (bus_req) breq_cyc++;
                if (bus_req && !rd_strobe && !(memwrite | IOWrite1 | IOWrite2)) req_cyc++;
                if (rd_strobe) rlog.push_back(addr);
                if (32'($countones({memwrite, IOWrite1, IOWrite2})) > 1) strobe_err++;
                if (memwrite | IOWrite1 | IOWrite2) begin
                    wlog.push_back({(memwrite ? 2'd1 : (IOWrite1 ? 2'd2 : 2'd3)), addr, wr_data});
                    if (memwrite) mem[addr] = wr_data;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: grant held; 1: random grant; 2: grant dropped 3 cycles at first write;
    // 3: grant held plus a stray start pulse mid-transfer.
    task automatic run_xfer(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic [5:0] n, input int mode);
        logic [41:0] exp_w[$];
        logic [7:0]  exp_r[$];
        logic [7:0]  sa;
        logic [7:0]  da;
        logic [31:0] v;
        int wb, rb, db, bb, qb, eb, k, c, drop_end;
        logic dropped;
        sa = s;
        da = d;
        for (int i = 0; i < int'(n); i++) begin
            exp_r.push_back(sa);
            if (sa >= 8'd192) begin
                v = 32'hF000_0000 | ref_io;
                ref_io++;
            end else begin
                v = ref_mem[sa];
            end
            if (da < 8'd192) ref_mem[da] = v;
            exp_w.push_back({region(da), da, v});
            sa = step(sa);
            da = step(da);
        end
        wb = wlog.size(); rb = rlog.size(); db = done_cnt;
        bb = breq_cyc; qb = req_cyc; eb = strobe_err;
        dropped = 1'b0;
        drop_end = 0;
        @(posedge clock); #1;
        grant    = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        src_addr = s;
        dst_addr = d;
        count    = n;
        start    = 1'b1;
        k        = cyc;
        for (c = 0; c < 1000 && done_cnt == db; c++) begin
            @(posedge clock); #1;
            start = (mode == 3 && c == 3);
            if (start) begin
                src_addr = 8'($urandom);
                dst_addr = 8'($urandom);
                count    = 6'($urandom_range(1, 63));
            end
            if (mode == 1) grant = ($urandom_range(0, 3) != 0);
            if (mode == 2) begin
                if (!dropped && (memwrite | IOWrite1 | IOWrite2)) begin
                    grant = 1'b0;
                    dropped = 1'b1;
                    drop_end = cyc + 3;
                end else if (dropped && cyc == drop_end) begin
                    grant = 1'b1;
                end
            end
        end
        start = 1'b0;
        grant = 1'b1;
        check({tag, " done_pulses"}, 64'(done_cnt - db), 64'(1));
        if (mode == 0 || mode == 3) begin
            check({tag, " done_latency"}, 64'(done_cyc - k), (n == 0) ? 64'(1) : 64'(2 + 2 * int'(n)));
            check({tag, " bus_req_cycles"}, 64'(breq_cyc - bb), (n == 0) ? 64'(0) : 64'(1 + 2 * int'(n)));
        end
        if (mode == 2) check({tag, " req_cycles"}, 64'(req_cyc - qb), 64'(4));
        check({tag, " write_count"}, 64'(wlog.size() - wb), 64'(n));
        check({tag, " read_count"}, 64'(rlog.size() - rb), 64'(n));
        check({tag, " strobe_onehot"}, 64'(strobe_err - eb), 64'(0));
        for (int i = 0; i < exp_w.size(); i++) begin
            if (wb + i < wlog.size()) check($sformatf("%s write%0d", tag, i), 64'(wlog[wb + i]), 64'(exp_w[i]));
            if (rb + i < rlog.size()) check($sformatf("%s read%0d", tag, i), 64'(rlog[rb + i]), 64'(exp_r[i]));
        end
    endtask

    initial begin
        int wb, rb, rd_seen, diffs;
        logic [7:0] rs, rd;
        logic [5:0] rn;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0; grant = 1'b0;
        #2;
        check("reset_outputs", 64'({bus_req, busy, done, rd_strobe, memwrite, IOWrite1, IOWrite2, addr, wr_data}), 64'(0));
        #10 rst_n = 1'b1;

        run_xfer("mem2mem", 8'd10, 8'd100, 6'd4, 0);
        run_xfer("mem2io2", 8'd0, 8'd230, 6'd3, 0);
        run_xfer("io1_2mem_wrap", 8'd200, 8'd190, 6'd3, 0);
        run_xfer("grant_loss", 8'd50, 8'd150, 6'd3, 2);
        run_xfer("count0", 8'd7, 8'd8, 6'd0, 0);
        run_xfer("stray_start", 8'd30, 8'd120, 6'd4, 3);
        run_xfer("max_block", 8'd5, 8'd180, 6'd63, 0);
        for (int t = 0; t < 20; t++) begin
            rs = 8'($urandom);
            rd = 8'($urandom);
            rn = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 24));
            run_xfer($sformatf("rand%0d", t), rs, rd, rn, int'($urandom_range(0, 1)));
        end

        // Reset during the second READ of a 5-word move: only the first word lands.
        wb = wlog.size();
        rb = rlog.size();
        rd_seen = 0;
        @(posedge clock); #1;
        grant = 1'b1; src_addr = 8'd20; dst_addr = 8'd60; count = 6'd5; start = 1'b1;
        for (int c = 0; c < 50 && rd_seen < 2; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (rd_strobe) rd_seen++;
        end
        check("rst_reached_read2", 64'(rd_seen), 64'(2));
        rst_n = 1'b0;
        #1;
        check("rst_outputs_now", 64'({bus_req, busy, done, rd_strobe, memwrite, IOWrite1, IOWrite2, addr, wr_data}), 64'(0));
        ref_mem[60] = ref_mem[20];
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("rst_busy_after", 64'(busy), 64'(0));
        check("rst_writes", 64'(wlog.size() - wb), 64'(1));
        check("rst_reads", 64'(rlog.size() - rb), 64'(1));
        if (wlog.size() > wb) check("rst_first_word", 64'(wlog[wb]), 64'({2'd1, 8'd60, ref_mem[60]}));

        diffs = 0;
        for (int i = 0; i < 192; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("memory_image", 64'(diffs), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
